glitch_trigger_seq: RTL and testbench

//   Sequencer directly downstream of the n-adic cycle counter in the glitchy-clock generator.

---
 rtl/glitch_trigger_seq.sv | 137 +++++++++++++
 tb/tb_glitch_trigger_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_trigger_seq.sv
// rtl/glitch_trigger_seq.sv - counter-match glitch window sequencer driving the glitchy-clock mux select
module glitch_trigger_seq #(
    parameter int CW = 32,
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          arm,
    input  logic          abort,
    input  logic [CW-1:0] target,
    input  logic [WW-1:0] width,
    input  logic [WW-1:0] reps,
    input  logic [CW-1:0] cnt,
    output logic          cnt_exec,
    output logic          glitch_sel,
    output logic [WW-1:0] glitch_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_GLITCH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] target_q, target_d;
    logic [WW-1:0] width_q, width_d;
    logic [WW-1:0] reps_q, reps_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [WW-1:0] idx_q, idx_d;
    logic          sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          exec_q, exec_d;
    logic          done_q, done_d;

    // One extra bit so idx+1 cannot wrap before the comparison against reps_q.
    logic [WW:0]   idx_next;
    assign idx_next = {1'b0, idx_q} + {{WW{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            width_q  <= '0;
            reps_q   <= '0;
            wcnt_q   <= '0;
            idx_q    <= '0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            exec_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            width_q  <= width_d;
            reps_q   <= reps_d;
            wcnt_q   <= wcnt_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            exec_q   <= exec_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        width_d  = width_q;
        reps_d   = reps_q;
        wcnt_d   = wcnt_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        exec_d   = exec_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arm && !abort) begin
                    target_d = target;
                    width_d  = (width == '0) ? {{(WW-1){1'b0}}, 1'b1} : width;
                    reps_d   = (reps == '0) ? {{(WW-1){1'b0}}, 1'b1} : reps;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    exec_d   = 1'b1;
                    state_d  = S_ARMED;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    sel_d   = 1'b0;
                    busy_d  = 1'b0;
                    exec_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt == target_q) begin
                    sel_d   = 1'b1;
                    wcnt_d  = width_q - {{(WW-1){1'b0}}, 1'b1};
                    state_d = S_GLITCH;
                end
            end
            S_GLITCH: begin
                if (abort) begin
                    sel_d   = 1'b0;
                    busy_d  = 1'b0;
                    exec_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - {{(WW-1){1'b0}}, 1'b1};
                end else begin
                    sel_d = 1'b0;
                    if (idx_next < {1'b0, reps_q}) begin
                        idx_d   = idx_next[WW-1:0];
                        state_d = S_ARMED;
                    end else begin
                        busy_d  = 1'b0;
                        exec_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cnt_exec   = exec_q;
    assign glitch_sel = sel_q;
    assign glitch_idx = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_glitch_trigger_seq.sv
// tb/tb_glitch_trigger_seq.sv - directed self-checking bench for glitch_trigger_seq
module tb_glitch_trigger_seq;

    localparam int CW = 32;
    localparam int WW = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          arm;
    logic          abort;
    logic [CW-1:0] target;
    logic [WW-1:0] width;
    logic [WW-1:0] reps;
    logic [CW-1:0] cnt;
    logic          cnt_exec;
    logic          glitch_sel;
    logic [WW-1:0] glitch_idx;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_n    = 9;

    int          nwin;
    int          ndone;
    int          done_cyc;
    int          rise_c   [8];
    logic [31:0] rise_cnt [8];
    int          win_len  [8];
    logic [31:0] win_idx  [8];

    glitch_trigger_seq #(.CW(CW), .WW(WW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .arm        (arm),
        .abort      (abort),
        .target     (target),
        .width      (width),
        .reps       (reps),
        .cnt        (cnt),
        .cnt_exec   (cnt_exec),
        .glitch_sel (glitch_sel),
        .glitch_idx (glitch_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // n-adic counter model: counts 0..cnt_n while exec is high, held at 0 otherwise.
    always @(posedge clk) begin
        if (!rstn || !cnt_exec) cnt <= '0;
        else if (cnt == CW'(cnt_n)) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [CW-1:0] t, input logic [WW-1:0] w, input logic [WW-1:0] r);
        target = t;
        width  = w;
        reps   = r;
        arm    = 1'b1;
        step();
        arm    = 1'b0;
        // Later field changes must not affect the running sequence.
        target = 32'd7;
        width  = 8'd9;
        reps   = 8'd9;
    endtask

    task automatic run_mon(input int budget, input int abort_at);
        logic        prev_sel;
        logic [31:0] pc;
        nwin     = 0;
        ndone    = 0;
        done_cyc = -1;
        prev_sel = glitch_sel;
        for (int c = 1; c <= budget; c++) begin
            pc = cnt;
            if (c == abort_at) abort = 1'b1;
            step();
            abort = 1'b0;
            if (glitch_sel && !prev_sel && nwin < 8) begin
                rise_c[nwin]   = c;
                rise_cnt[nwin] = pc;
                win_len[nwin]  = 1;
                win_idx[nwin]  = 32'(glitch_idx);
                nwin++;
            end else if (glitch_sel && nwin > 0) begin
                win_len[nwin-1]++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = c;
            end
            prev_sel = glitch_sel;
        end
    endtask

    initial begin
        rstn   = 1'b0;
        arm    = 1'b0;
        abort  = 1'b0;
        target = '0;
        width  = '0;
        reps   = '0;
        step();
        step();
        check("rst_sel",  32'(glitch_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_exec", 32'(cnt_exec), 0);
        check("rst_done", 32'(done), 0);
        check("rst_idx",  32'(glitch_idx), 0);
        rstn = 1'b1;
        step();

        // Single window: target 3, width 2
        cnt_n = 9;
        do_arm(32'd3, 8'd2, 8'd1);
        check("t2_busy", 32'(busy), 1);
        check("t2_exec", 32'(cnt_exec), 1);
        run_mon(12, 0);
        check("t2_nwin",  32'(nwin), 1);
        check("t2_rise",  32'(rise_c[0]), 4);
        check("t2_cnt",   rise_cnt[0], 3);
        check("t2_len",   32'(win_len[0]), 2);
        check("t2_ndone", 32'(ndone), 1);
        check("t2_dcyc",  32'(done_cyc), 6);
        check("t2_busy_end", 32'(busy), 0);

        // Repeat: three one-cycle windows a counter period apart
        do_arm(32'd5, 8'd1, 8'd3);
        run_mon(35, 0);
        check("t3_nwin", 32'(nwin), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_rise%0d", i), 32'(rise_c[i]), 32'(6 + 10 * i));
            check($sformatf("t3_cnt%0d", i),  rise_cnt[i], 5);
            check($sformatf("t3_len%0d", i),  32'(win_len[i]), 1);
            check($sformatf("t3_idx%0d", i),  win_idx[i], 32'(i));
        end
        check("t3_ndone", 32'(ndone), 1);
        check("t3_dcyc",  32'(done_cyc), 27);
        check("t3_idx_end", 32'(glitch_idx), 2);

        // Zero width/reps behave as one
        do_arm(32'd3, 8'd0, 8'd0);
        run_mon(12, 0);
        check("t4_nwin",  32'(nwin), 1);
        check("t4_rise",  32'(rise_c[0]), 4);
        check("t4_len",   32'(win_len[0]), 1);
        check("t4_ndone", 32'(ndone), 1);
        check("t4_dcyc",  32'(done_cyc), 5);

        // Overlapping window skips a wrap; abort mid-second window
        cnt_n = 4;
        do_arm(32'd1, 8'd7, 8'd2);
        run_mon(25, 15);
        check("t5_nwin",  32'(nwin), 2);
        check("t5_rise0", 32'(rise_c[0]), 2);
        check("t5_len0",  32'(win_len[0]), 7);
        check("t5_rise1", 32'(rise_c[1]), 12);
        check("t5_len1",  32'(win_len[1]), 3);
        check("t5_idx1",  win_idx[1], 1);
        check("t5_ndone", 32'(ndone), 0);
        check("t5_busy",  32'(busy), 0);
        check("t5_exec",  32'(cnt_exec), 0);
        check("t5_idx_hold", 32'(glitch_idx), 1);

        // Unreachable target stays armed
        cnt_n = 9;
        do_arm(32'd20, 8'd1, 8'd1);
        run_mon(30, 0);
        check("t6_nwin",  32'(nwin), 0);
        check("t6_busy",  32'(busy), 1);
        check("t6_sel",   32'(glitch_sel), 0);
        check("t6_ndone", 32'(ndone), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_abort_busy", 32'(busy), 0);
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        check("t6_armabort_busy", 32'(busy), 0);
        check("t6_armabort_exec", 32'(cnt_exec), 0);
        step();
        check("t6_armabort_busy2", 32'(busy), 0);

        // Reset mid-GLITCH
        do_arm(32'd3, 8'd5, 8'd1);
        for (int i = 0; i < 5; i++) step();
        check("t1_sel_pre", 32'(glitch_sel), 1);
        rstn = 1'b0;
        step();
        check("t1_sel",  32'(glitch_sel), 0);
        check("t1_busy", 32'(busy), 0);
        check("t1_exec", 32'(cnt_exec), 0);
        check("t1_done", 32'(done), 0);
        rstn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
